alu32_arbiter: RTL and testbench

Shares a single `alu32` instance between two requesters (e.g. integer pipe and address/branch helper) using round-robin arbitration with valid/ready handshakes on both the request and response sides. Each requester has a one-entry registered response slot. The block provides one ALU operation per cycle of aggregate throughput and one cycle of latency. It sits between the issue logic and the shared `alu32` datapath and owns all sequencing of that datapath.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu32.sv | 38 +++
 rtl/alu32_arbiter.sv | 112 +++++++++++
 tb/tb_alu32_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: select encodings shared by the ALU, the arbiter in front of it and the decoder.
//   ALU_* : 4-bit select constants
//   alu_sel_legal(sel) : 1 when sel names an implemented operation
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  function automatic logic alu_sel_legal(input logic [3:0] sel);
    logic legal;
    case (sel)
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND: legal = 1'b1;
      default:                                    legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu32.sv
// alu32: combinational integer ALU.
//   X, Y   : operands
//   select : operation (alu_pkg encodings); unsupported selects yield 0
//   result : operation result
module alu32
  import alu_pkg::*;
#(
  parameter int unsigned n = 32
) (
  input  logic [n-1:0] X,
  input  logic [n-1:0] Y,
  input  logic [3:0]   select,
  output logic [n-1:0] result
);

  localparam int unsigned ShW = $clog2(n);

  logic [ShW-1:0] shamt;
  assign shamt = Y[ShW-1:0];

  always_comb begin
    result = '0;
    case (select)
      ALU_ADD:  result = X + Y;
      ALU_SUB:  result = X - Y;
      ALU_SLL:  result = X << shamt;
      ALU_SLT:  result = {{(n-1){1'b0}}, $signed(X) < $signed(Y)};
      ALU_SLTU: result = {{(n-1){1'b0}}, X < Y};
      ALU_XOR:  result = X ^ Y;
      ALU_SRL:  result = X >> shamt;
      ALU_SRA:  result = $unsigned($signed(X) >>> shamt);
      ALU_OR:   result = X | Y;
      ALU_AND:  result = X & Y;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu32_arbiter.sv
// alu32_arbiter: shares one alu32 between two requesters with round-robin arbitration.
//   req_valid/req_ready : per-requester request handshake (req_ready one-hot or zero)
//   req_x/req_y/req_sel : packed operands and selects, requester i in slice i
//   rsp_valid/rsp_ready : per-requester one-entry response slot handshake
//   rsp_result/rsp_err  : registered result and unsupported-select flag per slot
module alu32_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned n = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [2*n-1:0] req_x,
  input  logic [2*n-1:0] req_y,
  input  logic [7:0]     req_sel,
  output logic [1:0]     rsp_valid,
  input  logic [1:0]     rsp_ready,
  output logic [2*n-1:0] rsp_result,
  output logic [1:0]     rsp_err
);

  logic           last_grant_q, last_grant_d;
  logic [1:0]     slot_valid_q, slot_valid_d;
  logic [1:0]     slot_err_q, slot_err_d;
  logic [2*n-1:0] slot_res_q, slot_res_d;

  logic [1:0]   elig;
  logic [1:0]   gnt;
  logic         gnt_idx;
  logic [n-1:0] alu_x, alu_y, alu_res;
  logic [3:0]   alu_sel;
  logic         sel_legal;

  // A slot being drained this cycle can accept a new result on the same edge.
  assign elig = req_valid & (~slot_valid_q | rsp_ready);

  always_comb begin
    gnt = 2'b00;
    case (elig)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  assign gnt_idx   = gnt[1];
  assign req_ready = rst_n ? gnt : 2'b00;

  // Idle inputs are parked at ADD 0,0 so the datapath does not toggle.
  always_comb begin
    alu_x   = '0;
    alu_y   = '0;
    alu_sel = ALU_ADD;
    if (gnt != 2'b00) begin
      alu_x   = req_x[n*32'(gnt_idx) +: n];
      alu_y   = req_y[n*32'(gnt_idx) +: n];
      alu_sel = req_sel[4*32'(gnt_idx) +: 4];
    end
  end

  assign sel_legal = alu_sel_legal(alu_sel);

  alu32 #(
    .n(n)
  ) u_alu32 (
    .X     (alu_x),
    .Y     (alu_y),
    .select(alu_sel),
    .result(alu_res)
  );

  always_comb begin
    last_grant_d = last_grant_q;
    slot_valid_d = slot_valid_q;
    slot_err_d   = slot_err_q;
    slot_res_d   = slot_res_q;
    if (gnt != 2'b00) begin
      last_grant_d = gnt_idx;
    end
    for (int i = 0; i < 2; i++) begin
      if (gnt[i]) begin
        slot_valid_d[i]        = 1'b1;
        slot_err_d[i]          = ~sel_legal;
        slot_res_d[n*i +: n]   = sel_legal ? alu_res : '0;
      end else if (rsp_ready[i]) begin
        slot_valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      slot_valid_q <= '0;
      slot_err_q   <= '0;
      slot_res_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      slot_valid_q <= slot_valid_d;
      slot_err_q   <= slot_err_d;
      slot_res_q   <= slot_res_d;
    end
  end

  assign rsp_valid  = slot_valid_q;
  assign rsp_err    = slot_err_q;
  assign rsp_result = slot_res_q;

endmodule

// File: tb/tb_alu32_arbiter.sv
// Testbench for alu32_arbiter: directed scenarios followed by random traffic,
// all checked against a behavioural model of the arbiter and ALU.
module tb_alu32_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_x;
  logic [63:0] req_y;
  logic [7:0]  req_sel;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [63:0] rsp_result;
  logic [1:0]  rsp_err;

  alu32_arbiter #(
    .n(32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_sel   (req_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_result(rsp_result),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: what each response slot should hold, and who won last.
  logic        m_valid [2];
  logic [31:0] m_res   [2];
  logic        m_err   [2];
  int          m_last;
  logic [1:0]  last_g;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_legal(input logic [3:0] s);
    return !(s inside {4'd9, 4'd10, 4'd11, 4'd12, 4'd14, 4'd15});
  endfunction

  function automatic logic [31:0] ref_alu(input logic [31:0] x, input logic [31:0] y,
                                          input logic [3:0] s);
    int signed   sx, sy;
    int unsigned sh;
    sx = x;
    sy = y;
    sh = y % 32;
    case (s)
      4'd0:    return x + y;
      4'd8:    return x - y;
      4'd1:    return x << sh;
      4'd2:    return (sx < sy) ? 32'd1 : 32'd0;
      4'd3:    return (x < y) ? 32'd1 : 32'd0;
      4'd4:    return x ^ y;
      4'd5:    return x >> sh;
      4'd13:   return sx >>> sh;
      4'd6:    return x | y;
      4'd7:    return x & y;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0;
      m_res[i]   = '0;
      m_err[i]   = 1'b0;
    end
    m_last = 1;
    last_g = 2'b00;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_result", rsp_result, 64'd0);
    chk("rst_rsp_err", {62'd0, rsp_err}, 64'd0);
    chk("rst_req_ready", {62'd0, req_ready}, 64'd0);
  endtask

  // One clock: check the grant, advance the model over the edge, check the slots.
  task automatic step();
    logic [1:0] elig, g;
    #1;
    for (int i = 0; i < 2; i++) elig[i] = req_valid[i] && (!m_valid[i] || rsp_ready[i]);
    if (elig == 2'b11) g = (m_last == 1) ? 2'b01 : 2'b10;
    else g = elig;
    chk("req_ready", {62'd0, req_ready}, {62'd0, g});
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (g[i]) begin
        m_valid[i] = 1'b1;
        m_err[i]   = !is_legal(req_sel[4*i +: 4]);
        m_res[i]   = ref_alu(req_x[32*i +: 32], req_y[32*i +: 32], req_sel[4*i +: 4]);
        m_last     = i;
      end else if (rsp_ready[i]) begin
        m_valid[i] = 1'b0;
      end
    end
    last_g = g;
    #1;
    chk("rsp_valid", {62'd0, rsp_valid}, {62'd0, m_valid[1], m_valid[0]});
    for (int i = 0; i < 2; i++) begin
      if (m_valid[i]) begin
        chk($sformatf("rsp_result%0d", i), {32'd0, rsp_result[32*i +: 32]}, {32'd0, m_res[i]});
        chk($sformatf("rsp_err%0d", i), {63'd0, rsp_err[i]}, {63'd0, m_err[i]});
      end
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] s,
                         input logic [31:0] x, input logic [31:0] y);
    req_valid[i]      = v;
    req_sel[4*i +: 4] = s;
    req_x[32*i +: 32] = x;
    req_y[32*i +: 32] = y;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_x     = '0;
    req_y     = '0;
    req_sel   = '0;
    rsp_ready = 2'b00;
    model_reset();
    #2;
    chk_reset_outputs();
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 2'b00;

    // Single request.
    set_req(0, 1'b1, 4'b0000, 32'd10, 32'd20);
    step();
    chk("single_res", {32'd0, rsp_result[31:0]}, 64'd30);
    set_req(0, 1'b0, 4'b0000, 32'd0, 32'd0);
    rsp_ready = 2'b01;
    step();

    // Tie with both consuming every cycle.
    set_req(0, 1'b1, 4'b1000, 32'd50, 32'd30);
    set_req(1, 1'b1, 4'b0100, 32'd15, 32'd30);
    rsp_ready = 2'b11;
    repeat (4) step();
    chk("tie_res0", {32'd0, rsp_result[31:0]}, 64'd20);
    chk("tie_res1", {32'd0, rsp_result[63:32]}, 64'd17);

    // Backpressure on slot 1 while requester 0 streams.
    req_valid = 2'b00;
    step();
    set_req(1, 1'b1, 4'b0010, 32'd10, 32'd15);
    rsp_ready = 2'b00;
    step();
    set_req(0, 1'b1, 4'b0000, 32'd3, 32'd4);
    rsp_ready = 2'b01;
    repeat (5) begin
      step();
      chk("bp_grant0", {62'd0, last_g}, 64'd1);
      chk("bp_hold1", {32'd0, rsp_result[63:32]}, 64'd1);
    end

    // Same-cycle drain and refill of slot 0.
    set_req(1, 1'b0, 4'b0000, 32'd0, 32'd0);
    set_req(0, 1'b1, 4'b1101, 32'hFFFF_FFF0, 32'd1);
    step();
    chk("refill_res", {32'd0, rsp_result[31:0]}, 64'h0000_0000_FFFF_FFF8);

    // Unsupported select.
    set_req(0, 1'b1, 4'b1111, 32'd7, 32'd7);
    step();
    chk("illegal_err", {63'd0, rsp_err[0]}, 64'd1);

    // Reset with both slots full.
    set_req(0, 1'b1, 4'b0110, 32'h0F0, 32'h00F);
    set_req(1, 1'b1, 4'b0111, 32'hFF0, 32'h0FF);
    rsp_ready = 2'b00;
    repeat (2) step();
    chk("pre_rst_valid", {62'd0, rsp_valid}, 64'd3);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    model_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 2'b11;
    step();
    chk("post_rst_tie", {62'd0, last_g}, 64'd1);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!(req_valid[i] && !last_g[i])) begin
          set_req(i, ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
                  ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)));
        end
        rsp_ready[i] = ($urandom_range(0, 2) != 0);
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
